// File: rtl/mem_stage_if.sv
// mem_stage_if: bundles the EX->MEM, SRAM read-data and MEM->WB/ID buses of the MEM stage.
// Ports: master drives stall, ex_to_mem_bus, ex_to_mem_hilo and data_sram_rdata, and reads the results;
//        slave (the stage) reads those inputs and drives mem_to_wb_bus, mem_to_id_bus, mem_to_wb_hilo and mem_to_id_hilo.
interface mem_stage_if #(
   parameter int EX_TO_MEM_WD = 80,
   parameter int MEM_TO_WB_WD = 70,
   parameter int STALL_WD     = 6
);
   logic [STALL_WD-1:0]     stall;
   logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
   logic [65:0]             ex_to_mem_hilo;
   logic [31:0]             data_sram_rdata;
   logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus;
   logic [37:0]             mem_to_id_bus;
   logic [65:0]             mem_to_wb_hilo;
   logic [65:0]             mem_to_id_hilo;

   modport master (
      output stall, ex_to_mem_bus, ex_to_mem_hilo, data_sram_rdata,
      input  mem_to_wb_bus, mem_to_id_bus, mem_to_wb_hilo, mem_to_id_hilo
   );

   modport slave (
      input  stall, ex_to_mem_bus, ex_to_mem_hilo, data_sram_rdata,
      output mem_to_wb_bus, mem_to_id_bus, mem_to_wb_hilo, mem_to_id_hilo
   );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage of the 5-stage MIPS core; registers EX->MEM, aligns/extends SRAM load data.
// Latency: 1 cycle ex_to_mem_bus -> mem_to_wb_bus; ID forwarding copies are combinational off the same register.
// Backpressure: stall[3] holds the stage (stall[4]=1) or injects a bubble (stall[4]=0); load data is held across stalls.
// Ports: clk; rst (synchronous, active-high); mem_if (slave): stall, ex_to_mem_bus, ex_to_mem_hilo, data_sram_rdata in;
//        mem_to_wb_bus {pc,rf_we,rf_waddr,rf_wdata}, mem_to_id_bus {rf_we,rf_waddr,rf_wdata}, mem_to_wb_hilo, mem_to_id_hilo out.
module mem_stage #(
   parameter int EX_TO_MEM_WD = 80,
   parameter int MEM_TO_WB_WD = 70,
   parameter int STALL_WD     = 6
) (
   input  logic       clk,
   input  logic       rst,
   mem_stage_if.slave mem_if
);

   typedef struct packed {
      logic [31:0] pc;
      logic        ram_en;
      logic [3:0]  ram_wen;
      logic        sel_rf_res;
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic [31:0] ex_result;
      logic [3:0]  ram_read;
   } ex_mem_t;

   typedef struct packed {
      logic        hi_we;
      logic        lo_we;
      logic [31:0] hi;
      logic [31:0] lo;
   } hilo_t;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } hold_state_e;

   logic [STALL_WD-1:0]     stall_w;
   logic [EX_TO_MEM_WD-1:0] ex_bus_w;
   logic [MEM_TO_WB_WD-1:0] wb_bus_w;

   ex_mem_t     ex_in;
   hilo_t       hilo_in;
   ex_mem_t     bus_d,  bus_q;
   hilo_t       hilo_d, hilo_q;
   hold_state_e state_q;
   logic [31:0] rdata_h_q;

   logic        stall_mem;
   logic        stall_wb;
   logic        bubble;
   logic        load_in_mem;
   logic [31:0] rdata_eff;
   logic [1:0]  addr_lo;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] load_data;
   logic [31:0] rf_wdata;

   assign stall_w  = mem_if.stall;
   assign ex_bus_w = mem_if.ex_to_mem_bus;
   assign ex_in    = ex_mem_t'(ex_bus_w);
   assign hilo_in  = hilo_t'(mem_if.ex_to_mem_hilo);

   assign stall_mem = stall_w[3];
   assign stall_wb  = stall_w[4];
   // MEM stopped while WB keeps going: WB must see a bubble, not a repeat.
   assign bubble    = stall_mem & ~stall_wb;

   // ---------------- pipeline register ----------------
   always_comb begin
      bus_d  = bus_q;
      hilo_d = hilo_q;
      if (bubble) begin
         bus_d  = '0;
         hilo_d = '0;
      end else if (!stall_mem) begin
         bus_d  = ex_in;
         hilo_d = hilo_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus_q  <= '0;
         hilo_q <= '0;
      end else begin
         bus_q  <= bus_d;
         hilo_q <= hilo_d;
      end
   end

   // ---------------- read-data hold FSM ----------------
   // The SRAM only presents the word for one cycle after EX issued the address;
   // if the load sits stalled in MEM, that word is captured before it disappears.
   assign load_in_mem = bus_q.ram_en & bus_q.sel_rf_res;

   always_ff @(posedge clk) begin
      if (rst || bubble) begin
         state_q   <= IDLE;
         rdata_h_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (stall_mem && load_in_mem) begin
                  state_q   <= HOLD;
                  rdata_h_q <= mem_if.data_sram_rdata;
               end
            end
            HOLD: begin
               if (!stall_mem) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rdata_eff = (state_q == HOLD) ? rdata_h_q : mem_if.data_sram_rdata;

   // ---------------- load alignment ----------------
   assign addr_lo = bus_q.ex_result[1:0];

   always_comb begin
      case (addr_lo)
         2'd0:    ld_byte = rdata_eff[7:0];
         2'd1:    ld_byte = rdata_eff[15:8];
         2'd2:    ld_byte = rdata_eff[23:16];
         default: ld_byte = rdata_eff[31:24];
      endcase
      // Halfword select ignores addr_lo[0]; misaligned halfword loads are not trapped here.
      ld_half = addr_lo[1] ? rdata_eff[31:16] : rdata_eff[15:0];

      case (bus_q.ram_read)
         4'b1111: load_data = rdata_eff;
         4'b0001: load_data = {{24{ld_byte[7]}}, ld_byte};
         4'b0010: load_data = {24'h0, ld_byte};
         4'b0011: load_data = {{16{ld_half[15]}}, ld_half};
         4'b0100: load_data = {16'h0, ld_half};
         default: load_data = rdata_eff;
      endcase
   end

   assign rf_wdata = bus_q.sel_rf_res ? load_data : bus_q.ex_result;

   // ---------------- outputs ----------------
   assign wb_bus_w              = {bus_q.pc, bus_q.rf_we, bus_q.rf_waddr, rf_wdata};
   assign mem_if.mem_to_wb_bus  = wb_bus_w;
   assign mem_if.mem_to_id_bus  = wb_bus_w[37:0];
   assign mem_if.mem_to_wb_hilo = hilo_q;
   assign mem_if.mem_to_id_hilo = hilo_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vectors plus randomized run against a behavioural model of the MEM stage.
// Latency: n/a.
// Backpressure: drives stall patterns directly.
module tb_mem_stage;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_stage_if #(.EX_TO_MEM_WD(80), .MEM_TO_WB_WD(70), .STALL_WD(6)) m_if ();

   mem_stage #(.EX_TO_MEM_WD(80), .MEM_TO_WB_WD(70), .STALL_WD(6)) dut (
      .clk    (clk),
      .rst    (rst),
      .mem_if (m_if)
   );

   int checks = 0;
   int errors = 0;

   localparam logic [5:0] ST_NONE   = 6'b000000;
   localparam logic [5:0] ST_HOLD   = 6'b011000;
   localparam logic [5:0] ST_BUBBLE = 6'b001000;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_in(input logic [5:0] st, input logic [79:0] ex, input logic [65:0] hl, input logic [31:0] rd);
      m_if.stall           = st;
      m_if.ex_to_mem_bus   = ex;
      m_if.ex_to_mem_hilo  = hl;
      m_if.data_sram_rdata = rd;
   endtask

   function automatic logic [79:0] mk_ex(input logic [31:0] pc, input logic ram_en, input logic sel,
                                         input logic we, input logic [4:0] waddr,
                                         input logic [31:0] res, input logic [3:0] rd);
      return {pc, ram_en, 4'b0000, sel, we, waddr, res, rd};
   endfunction

   // Reference load extraction: shift the addressed lane down, then extend.
   function automatic logic [31:0] ref_load(input logic [3:0] code, input logic [1:0] a, input logic [31:0] w);
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'(w >> (int'(a) * 8));
      h = 16'(w >> (int'(a[1]) * 16));
      case (code)
         4'b0001: return 32'($signed(b));
         4'b0010: return 32'(b);
         4'b0011: return 32'($signed(h));
         4'b0100: return 32'(h);
         default: return w;
      endcase
   endfunction

   typedef struct {
      string       name;
      logic [3:0]  code;
      logic [1:0]  a;
      logic [31:0] rdata;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[13];

   // behavioural model state for the random run
   logic [79:0] m_bus;
   logic [65:0] m_hilo;
   int          m_age;
   logic [31:0] m_first;

   initial begin
      logic [3:0]  codes [8];
      logic [5:0]  st;
      logic [79:0] ex;
      logic [65:0] hl;
      logic [31:0] rd, word, wdata;
      logic        r_rst;

      vecs[0]  = '{"lb_a0",    4'b0001, 2'd0, 32'h80FF7F01, 32'h00000001};
      vecs[1]  = '{"lb_a1",    4'b0001, 2'd1, 32'h80FF7F01, 32'h0000007F};
      vecs[2]  = '{"lb_a2",    4'b0001, 2'd2, 32'h80FF7F01, 32'hFFFFFFFF};
      vecs[3]  = '{"lb_a3",    4'b0001, 2'd3, 32'h80FF7F01, 32'hFFFFFF80};
      vecs[4]  = '{"lbu_a3",   4'b0010, 2'd3, 32'h80FF7F01, 32'h00000080};
      vecs[5]  = '{"lh_a2",    4'b0011, 2'd2, 32'h80FF7F01, 32'hFFFF80FF};
      vecs[6]  = '{"lhu_a0",   4'b0100, 2'd0, 32'h80FF7F01, 32'h00007F01};
      vecs[7]  = '{"lw_a0",    4'b1111, 2'd0, 32'h80FF7F01, 32'h80FF7F01};
      vecs[8]  = '{"lh_a0",    4'b0011, 2'd0, 32'h80FF7F01, 32'h00007F01};
      vecs[9]  = '{"lhu_a2",   4'b0100, 2'd2, 32'h80FF7F01, 32'h000080FF};
      vecs[10] = '{"lbu_a1",   4'b0010, 2'd1, 32'h80FF7F01, 32'h0000007F};
      vecs[11] = '{"other_a2", 4'b1000, 2'd2, 32'h80FF7F01, 32'h80FF7F01};
      vecs[12] = '{"lh_a3",    4'b0011, 2'd3, 32'h80FF7F01, 32'hFFFF80FF};

      // ---- reset with random inputs ----
      rst = 1'b1;
      set_in(6'($urandom), 80'({$urandom, $urandom, $urandom}), 66'({$urandom, $urandom, $urandom}), $urandom);
      @(negedge clk);
      set_in(6'($urandom), 80'({$urandom, $urandom, $urandom}), 66'({$urandom, $urandom, $urandom}), $urandom);
      @(negedge clk);
      #1;
      chk("rst_wb_bus",  m_if.mem_to_wb_bus,  '0);
      chk("rst_id_bus",  m_if.mem_to_id_bus,  '0);
      chk("rst_wb_hilo", m_if.mem_to_wb_hilo, '0);
      chk("rst_id_hilo", m_if.mem_to_id_hilo, '0);

      // ---- lw, one cycle latency ----
      rst = 1'b0;
      set_in(ST_NONE, mk_ex(32'h400, 1, 1, 1, 5'd8, 32'h100, 4'b1111), '0, $urandom);
      @(negedge clk);
      set_in(ST_NONE, '0, '0, 32'hDEADBEEF);
      #1;
      chk("lw_wb_bus", m_if.mem_to_wb_bus, {32'h400, 1'b1, 5'd8, 32'hDEADBEEF});
      chk("lw_id_bus", m_if.mem_to_id_bus, {1'b1, 5'd8, 32'hDEADBEEF});

      // ---- alignment table ----
      for (int i = 0; i < 13; i++) begin
         set_in(ST_NONE, mk_ex(32'h1000 + 32'(i), 1, 1, 1, 5'd4, {30'h40, vecs[i].a}, vecs[i].code), '0, $urandom);
         @(negedge clk);
         set_in(ST_NONE, '0, '0, vecs[i].rdata);
         #1;
         chk(vecs[i].name, m_if.mem_to_wb_bus[31:0], vecs[i].exp);
      end

      // ---- lw held across a 3-cycle stall while SRAM data changes ----
      set_in(ST_NONE, mk_ex(32'h500, 1, 1, 1, 5'd9, 32'h200, 4'b1111), '0, $urandom);
      @(negedge clk);
      set_in(ST_HOLD, '0, '0, 32'h12345678);
      #1 chk("hold_c1", m_if.mem_to_wb_bus, {32'h500, 1'b1, 5'd9, 32'h12345678});
      @(negedge clk);
      m_if.data_sram_rdata = 32'h0;
      #1 chk("hold_c2", m_if.mem_to_wb_bus, {32'h500, 1'b1, 5'd9, 32'h12345678});
      @(negedge clk);
      #1 chk("hold_c3", m_if.mem_to_id_bus, {1'b1, 5'd9, 32'h12345678});
      @(negedge clk);
      set_in(ST_NONE, mk_ex(32'h504, 0, 0, 1, 5'd2, 32'h77, 4'b0000), '0, 32'h0);
      #1 chk("hold_release", m_if.mem_to_wb_bus, {32'h500, 1'b1, 5'd9, 32'h12345678});
      @(negedge clk);
      #1 chk("after_release", m_if.mem_to_wb_bus, {32'h504, 1'b1, 5'd2, 32'h77});

      // ---- bubble ----
      set_in(ST_NONE, mk_ex(32'h600, 0, 0, 1, 5'd3, 32'h99, 4'b0000), {2'b11, 32'h1, 32'h2}, 32'h0);
      @(negedge clk);
      #1 chk("pre_bubble", m_if.mem_to_wb_hilo, {2'b11, 32'h1, 32'h2});
      set_in(ST_BUBBLE, mk_ex(32'h604, 0, 0, 1, 5'd5, 32'h98, 4'b0000), {2'b11, 32'h3, 32'h4}, 32'h0);
      @(negedge clk);
      #1;
      chk("bubble_wb_bus",  m_if.mem_to_wb_bus,  '0);
      chk("bubble_wb_hilo", m_if.mem_to_wb_hilo, '0);

      // ---- addu with HI/LO bundle ----
      set_in(ST_NONE, mk_ex(32'h700, 0, 0, 1, 5'd3, 32'h55, 4'b0000), {1'b1, 1'b1, 32'hA, 32'hB}, 32'hFFFF_FFFF);
      @(negedge clk);
      set_in(ST_NONE, '0, '0, 32'hFFFF_FFFF);
      #1;
      chk("addu_wb_bus",  m_if.mem_to_wb_bus,  {32'h700, 1'b1, 5'd3, 32'h55});
      chk("addu_id_hilo", m_if.mem_to_id_hilo, {1'b1, 1'b1, 32'hA, 32'hB});
      chk("addu_wb_hilo", m_if.mem_to_wb_hilo, {1'b1, 1'b1, 32'hA, 32'hB});

      // ---- stall on a non-load: output holds ex_result, no capture ----
      set_in(ST_NONE, mk_ex(32'h800, 0, 0, 1, 5'd6, 32'h1234, 4'b0000), '0, 32'h0);
      @(negedge clk);
      set_in(ST_HOLD, '0, '0, 32'hAAAA5555);
      @(negedge clk);
      #1 chk("nonload_hold", m_if.mem_to_wb_bus, {32'h800, 1'b1, 5'd6, 32'h1234});

      // ---- reset while in HOLD, then a fresh load uses live data ----
      set_in(ST_NONE, mk_ex(32'h900, 1, 1, 1, 5'd7, 32'h300, 4'b1111), '0, 32'h0);
      @(negedge clk);
      set_in(ST_HOLD, '0, '0, 32'hCAFEF00D);
      @(negedge clk);
      #1 chk("pre_rst_hold", m_if.mem_to_wb_bus[31:0], 32'hCAFEF00D);
      rst = 1'b1;
      m_if.data_sram_rdata = 32'h1;
      @(negedge clk);
      #1 chk("rst_in_hold", m_if.mem_to_wb_bus, '0);
      rst = 1'b0;
      set_in(ST_NONE, mk_ex(32'h904, 1, 1, 1, 5'd7, 32'h304, 4'b1111), '0, 32'h0);
      @(negedge clk);
      set_in(ST_NONE, '0, '0, 32'h00000077);
      #1 chk("post_rst_live", m_if.mem_to_wb_bus[31:0], 32'h00000077);

      // ---- back-to-back loads, no stall ----
      set_in(ST_NONE, mk_ex(32'hA00, 1, 1, 1, 5'd10, 32'h400, 4'b1111), '0, 32'h0);
      @(negedge clk);
      set_in(ST_NONE, mk_ex(32'hA04, 1, 1, 1, 5'd11, 32'h404, 4'b1111), '0, 32'h111);
      #1 chk("b2b_first", m_if.mem_to_wb_bus, {32'hA00, 1'b1, 5'd10, 32'h111});
      @(negedge clk);
      set_in(ST_NONE, '0, '0, 32'h222);
      #1 chk("b2b_second", m_if.mem_to_wb_bus, {32'hA04, 1'b1, 5'd11, 32'h222});

      // ---- randomized run against the behavioural model ----
      codes = '{4'b1111, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0111, 4'b0000};
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_bus = '0; m_hilo = '0; m_age = 0; m_first = '0;
      for (int n = 0; n < 400; n++) begin
         r_rst = ($urandom_range(0, 29) == 0);
         st    = 6'($urandom);
         st[3] = ($urandom_range(0, 2) == 0);
         st[4] = 1'($urandom_range(0, 1));
         ex    = 80'({$urandom, $urandom, $urandom});
         ex[3:0] = codes[$urandom_range(0, 7)];
         hl    = 66'({$urandom, $urandom, $urandom});
         rd    = $urandom;
         rst   = r_rst;
         set_in(st, ex, hl, rd);
         #1;
         // A load that has already sat through a stall edge sees the word from its first MEM cycle.
         word  = (m_age > 0 && m_bus[47] && m_bus[42]) ? m_first : rd;
         wdata = m_bus[42] ? ref_load(m_bus[3:0], m_bus[5:4], word) : m_bus[35:4];
         chk("rnd_wb_bus",  m_if.mem_to_wb_bus,  {m_bus[79:48], m_bus[41], m_bus[40:36], wdata});
         chk("rnd_id_bus",  m_if.mem_to_id_bus,  {m_bus[41], m_bus[40:36], wdata});
         chk("rnd_wb_hilo", m_if.mem_to_wb_hilo, m_hilo);
         chk("rnd_id_hilo", m_if.mem_to_id_hilo, m_hilo);
         if (r_rst || (st[3] && !st[4])) begin
            m_bus = '0; m_hilo = '0; m_age = 0;
         end else if (!st[3]) begin
            m_bus = ex; m_hilo = hl; m_age = 0;
         end else begin
            if (m_age == 0) m_first = rd;
            m_age++;
         end
         @(negedge clk);
      end
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
